// File: rtl/spi_slave_pkg.sv
// Shared constants and FSM state encoding for the SPI responder.
// The state enum is shared so that other blocks name the states the same way.
package spi_slave_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam int         BITC_W    = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer followed by a one-cycle delay stage for edge detection.
// Rise/fall pulses appear after two sync stages; the logic that consumes them acts on the following edge.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_dly  <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_dly;
  assign o_fall = ~r_sync & r_dly;

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI responder: oversamples Sck/CsN/Mosi, shifts words in MSB first and
// returns a preloaded word (or IDLE_TX on underrun) on Miso within the same frame.
//
//   state     | meaning
//   ST_IDLE   | deselected, Miso disabled, Sck ignored
//   ST_ACTIVE | selected, shifting on synchronized Sck edges
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int                 SPI_LEN = 8,
  parameter logic [SPI_LEN-1:0] IDLE_TX = {SPI_LEN{1'b1}}
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_sck,
  input  logic               i_cs_n,
  input  logic               i_mosi,
  output logic               o_miso,
  output logic               o_miso_oe,
  input  logic [SPI_LEN-1:0] i_tx_data,
  input  logic               i_tx_load,
  output logic               o_tx_ready,
  output logic [SPI_LEN-1:0] o_rx_data,
  output logic               o_rx_valid,
  output logic               o_underrun
);

  localparam logic [BITC_W-1:0] LEN_C = BITC_W'(SPI_LEN);

  logic w_sck_rise;
  logic w_sck_fall;
  logic w_cs_rise;
  logic w_cs_fall;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_sck),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_cs_n),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  // Mosi gets the same two-stage delay as Sck so it lines up with the rise pulse.
  logic r_mosi_meta;
  logic r_mosi_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_mosi_meta <= i_mosi;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  state_e              r_state;
  state_e              w_state_nxt;
  logic [BITC_W-1:0]   r_bitc;
  logic [SPI_LEN-1:0]  r_rx_shift;
  logic [SPI_LEN-1:0]  r_tx_shift;
  logic [SPI_LEN-1:0]  r_hold;
  logic                r_tx_ready;
  logic                r_skip_fall;
  logic [SPI_LEN-1:0]  r_rx_data;
  logic                r_rx_valid;
  logic                r_underrun;

  logic w_start;
  logic w_leave;
  logic w_word_done;
  logic w_reload;
  logic w_sample;
  logic w_shift;
  logic w_load_tx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_leave     = 1'b0;
    w_word_done = 1'b0;
    w_reload    = 1'b0;
    w_sample    = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Select wins over a coincident Sck edge; Sck is ignored here.
        if (w_cs_fall) begin
          w_state_nxt = ST_ACTIVE;
          w_start     = 1'b1;
        end
      end
      ST_ACTIVE: begin
        w_word_done = (r_bitc == LEN_C);
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
          w_leave     = 1'b1;
        end else begin
          w_reload = w_word_done;
          w_sample = w_sck_rise & ~w_word_done;
          w_shift  = w_sck_fall;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_load_tx = w_start | w_reload;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bitc      <= '0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '0;
      r_hold      <= '0;
      r_tx_ready  <= 1'b1;
      r_skip_fall <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;

      if (i_tx_load) begin
        r_hold <= i_tx_data;
      end

      // A load coinciding with a reload: the reload takes the old contents
      // and the newly captured word keeps the holding register full.
      if (i_tx_load) begin
        r_tx_ready <= 1'b0;
      end else if (w_load_tx && !r_tx_ready) begin
        r_tx_ready <= 1'b1;
      end

      if (w_load_tx) begin
        if (!r_tx_ready) begin
          r_tx_shift <= r_hold;
        end else begin
          r_tx_shift <= IDLE_TX;
          r_underrun <= 1'b1;
        end
      end else if (w_shift && !r_skip_fall) begin
        r_tx_shift <= r_tx_shift << 1;
      end

      // The fall right after a reload would drop the freshly loaded MSB.
      if (w_reload) begin
        r_skip_fall <= 1'b1;
      end else if (w_start || w_leave || w_shift) begin
        r_skip_fall <= 1'b0;
      end

      if (w_start || w_leave || w_word_done) begin
        r_bitc <= '0;
      end else if (w_sample) begin
        r_bitc <= r_bitc + 1'b1;
      end

      if (w_sample) begin
        r_rx_shift <= {r_rx_shift[SPI_LEN-2:0], r_mosi_sync};
      end

      if (w_word_done) begin
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end
    end
  end

  assign o_miso     = r_tx_shift[SPI_LEN-1];
  assign o_miso_oe  = (r_state == ST_ACTIVE);
  assign o_tx_ready = r_tx_ready;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_underrun = r_underrun;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed frames plus randomized traffic
// compared against a word-level model of the holding register and frame rules.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       underrun;

  always #5 clk = ~clk;

  spi_slave dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sck      (sck),
    .i_cs_n     (cs_n),
    .i_mosi     (mosi),
    .o_miso     (miso),
    .o_miso_oe  (miso_oe),
    .i_tx_data  (tx_data),
    .i_tx_load  (tx_load),
    .o_tx_ready (tx_ready),
    .o_rx_data  (rx_data),
    .o_rx_valid (rx_valid),
    .o_underrun (underrun)
  );

  int checks = 0;
  int errors = 0;

  // Monitor: log every received word and count underrun pulses.
  logic [7:0] rx_log[$];
  int         un_cnt = 0;

  always @(negedge clk) begin
    if (rx_valid) rx_log.push_back(rx_data);
    if (underrun) un_cnt++;
  end

  // Word-level model of the holding register.
  bit         pend_v;
  logic [7:0] pend_d;
  int         m_under;

  task automatic consume(output logic [7:0] w);
    if (pend_v) begin
      w      = pend_d;
      pend_v = 1'b0;
    end else begin
      w = 8'hFF;
      m_under++;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  // Master side of one word; optionally pulses TxLoad during bit 3's high phase.
  task automatic xfer(input logic [7:0] mo, input int nbits, input int hp,
                      input bit do_load, input logic [7:0] lv,
                      output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      tick(hp);
      mi[7-i] = miso;
      sck = 1'b1;
      if (do_load && i == 3) begin
        load(lv);
        tick(hp - 1);
      end else begin
        tick(hp);
      end
      sck = 1'b0;
    end
  endtask

  task automatic release_cs(input int hp);
    tick(hp);
    cs_n = 1'b1;
    tick(8);
  endtask

  task automatic test_reset;
    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_load = 1'b0; tx_data = '0;
    tick(4);
    checks++; if (miso !== 1'b0)     begin errors++; $display("FAIL reset_miso got %b want 0", miso); end
    checks++; if (miso_oe !== 1'b0)  begin errors++; $display("FAIL reset_oe got %b want 0", miso_oe); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", tx_ready); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rxdata got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rxvalid got %b want 0", rx_valid); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", underrun); end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_basic;
    logic [7:0] mi;
    int r0, u0;
    r0 = rx_log.size(); u0 = un_cnt;
    load(8'hA5);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_after_load got %b want 0", tx_ready); end
    cs_n = 1'b0;
    tick(4);
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after_sel got %b want 1", tx_ready); end
    checks++; if (miso_oe !== 1'b1)  begin errors++; $display("FAIL basic_oe got %b want 1", miso_oe); end
    checks++; if (un_cnt != u0)      begin errors++; $display("FAIL basic_no_underrun got %0d want %0d", un_cnt, u0); end
    xfer(8'h3C, 8, 4, 1'b0, 8'h00, mi);
    checks++; if (mi !== 8'hA5) begin errors++; $display("FAIL basic_miso got %h want a5", mi); end
    release_cs(4);
    checks++; if (rx_log.size() != r0 + 1) begin errors++; $display("FAIL basic_rxvalid_count got %0d want 1", rx_log.size() - r0); end
    else begin
      checks++; if (rx_log[r0] !== 8'h3C) begin errors++; $display("FAIL basic_rxdata got %h want 3c", rx_log[r0]); end
    end
    checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL basic_oe_after got %b want 0", miso_oe); end
  endtask

  task automatic test_underrun;
    logic [7:0] mi;
    int u0;
    u0 = un_cnt;
    cs_n = 1'b0;
    tick(4);
    checks++; if (un_cnt != u0 + 1) begin errors++; $display("FAIL underrun_at_sel got %0d want 1", un_cnt - u0); end
    xfer(8'h00, 8, 4, 1'b0, 8'h00, mi);
    checks++; if (mi !== 8'hFF) begin errors++; $display("FAIL underrun_miso got %h want ff", mi); end
    release_cs(4);
  endtask

  task automatic test_back_to_back;
    logic [7:0] mi1, mi2;
    int r0;
    r0 = rx_log.size();
    load(8'h55);
    cs_n = 1'b0;
    xfer(8'h12, 8, 4, 1'b1, 8'hAA, mi1);
    xfer(8'h34, 8, 4, 1'b0, 8'h00, mi2);
    release_cs(4);
    checks++; if (mi1 !== 8'h55) begin errors++; $display("FAIL b2b_miso1 got %h want 55", mi1); end
    checks++; if (mi2 !== 8'hAA) begin errors++; $display("FAIL b2b_miso2 got %h want aa", mi2); end
    checks++; if (rx_log.size() != r0 + 2) begin errors++; $display("FAIL b2b_rxvalid_count got %0d want 2", rx_log.size() - r0); end
    else begin
      checks++; if (rx_log[r0] !== 8'h12)   begin errors++; $display("FAIL b2b_rx1 got %h want 12", rx_log[r0]); end
      checks++; if (rx_log[r0+1] !== 8'h34) begin errors++; $display("FAIL b2b_rx2 got %h want 34", rx_log[r0+1]); end
    end
  endtask

  task automatic test_abort;
    logic [7:0] mi;
    int r0;
    r0 = rx_log.size();
    load(8'h5A);
    cs_n = 1'b0;
    xfer(8'hF0, 5, 4, 1'b0, 8'h00, mi);
    release_cs(4);
    checks++; if (rx_log.size() != r0) begin errors++; $display("FAIL abort_no_rxvalid got %0d want 0", rx_log.size() - r0); end
    checks++; if (miso_oe !== 1'b0)    begin errors++; $display("FAIL abort_oe got %b want 0", miso_oe); end
    load(8'hC3);
    cs_n = 1'b0;
    xfer(8'h96, 8, 4, 1'b0, 8'h00, mi);
    release_cs(4);
    checks++; if (mi !== 8'hC3) begin errors++; $display("FAIL abort_next_miso got %h want c3", mi); end
    checks++; if (rx_log.size() != r0 + 1) begin errors++; $display("FAIL abort_next_count got %0d want 1", rx_log.size() - r0); end
    else begin
      checks++; if (rx_log[r0] !== 8'h96) begin errors++; $display("FAIL abort_next_rx got %h want 96", rx_log[r0]); end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] mi;
    int r0, u0;
    load(8'h77);
    cs_n = 1'b0;
    xfer(8'hE1, 4, 4, 1'b0, 8'h00, mi);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (miso !== 1'b0)     begin errors++; $display("FAIL rstmid_miso got %b want 0", miso); end
    checks++; if (miso_oe !== 1'b0)  begin errors++; $display("FAIL rstmid_oe got %b want 0", miso_oe); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", tx_ready); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_rxdata got %h want 00", rx_data); end
    r0 = rx_log.size(); u0 = un_cnt;
    for (int i = 0; i < 4; i++) begin sck = 1'b1; tick(4); sck = 1'b0; tick(4); end
    cs_n = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    for (int i = 0; i < 8; i++) begin sck = 1'b1; tick(4); sck = 1'b0; tick(4); end
    checks++; if (rx_log.size() != r0) begin errors++; $display("FAIL rstmid_sck_ignored got %0d want 0", rx_log.size() - r0); end
    checks++; if (un_cnt != u0)        begin errors++; $display("FAIL rstmid_underrun got %0d want 0", un_cnt - u0); end
    checks++; if (miso_oe !== 1'b0)    begin errors++; $display("FAIL rstmid_oe_after got %b want 0", miso_oe); end
  endtask

  task automatic test_random(input int hp);
    logic [7:0] exp_rx[$];
    logic [7:0] cur, mi, mo, lv, d;
    int done, nw, r0, u0, mu0;
    bit dl;
    pend_v = 1'b0;
    done = 0; u0 = un_cnt; mu0 = m_under;
    while (done < 100) begin
      nw = $urandom_range(1, 4);
      if (nw > 100 - done) nw = 100 - done;
      if ($urandom_range(0, 3) != 0) begin
        d = 8'($urandom); load(d); pend_v = 1'b1; pend_d = d;
        if ($urandom_range(0, 3) == 0) begin
          d = 8'($urandom); load(d); pend_d = d;
        end
      end
      r0 = rx_log.size();
      exp_rx.delete();
      cs_n = 1'b0;
      consume(cur);
      for (int w = 0; w < nw; w++) begin
        mo = 8'($urandom);
        lv = 8'($urandom);
        dl = 1'($urandom_range(0, 1));
        xfer(mo, 8, hp, dl, lv, mi);
        if (dl) begin pend_v = 1'b1; pend_d = lv; end
        checks++; if (mi !== cur) begin errors++; $display("FAIL rand_miso hp=%0d word=%0d got %h want %h", hp, done + w, mi, cur); end
        consume(cur);
        exp_rx.push_back(mo);
      end
      release_cs(hp);
      checks++;
      if (rx_log.size() != r0 + nw) begin
        errors++; $display("FAIL rand_rx_count hp=%0d got %0d want %0d", hp, rx_log.size() - r0, nw);
      end else begin
        for (int w = 0; w < nw; w++) begin
          checks++; if (rx_log[r0+w] !== exp_rx[w]) begin errors++; $display("FAIL rand_rx hp=%0d word=%0d got %h want %h", hp, done + w, rx_log[r0+w], exp_rx[w]); end
        end
      end
      done += nw;
    end
    checks++; if (un_cnt - u0 != m_under - mu0) begin errors++; $display("FAIL rand_underrun hp=%0d got %0d want %0d", hp, un_cnt - u0, m_under - mu0); end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_under = 0;
    pend_v  = 1'b0;
    pend_d  = '0;
    test_reset;
    test_basic;
    test_underrun;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    test_random(3);
    test_random(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
